// File: rtl/arith_seq_pkg.sv
// Shared types and constants for the arithmetic-datapath sequencer.
package arith_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_EXCEPT    = 3'd5
  } state_t;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;

  // Wraps naturally at 2^32, so the word after 32'hFFFF_FFFC is 0.
  function automatic logic [31:0] next_pc(input logic [31:0] cur_pc);
    return cur_pc + PC_STEP;
  endfunction

endpackage

// File: rtl/arith_seq_perf.sv
// Retired-instruction and busy-cycle counters; only built with ARITH_SEQ_PERF_EN.
module arith_seq_perf (
  input  logic        clock,
  input  logic        reset,
  input  logic        retire,
  input  logic        busy,
  output logic [31:0] retired_cnt,
  output logic [31:0] cycle_cnt
);

  logic [31:0] retired_reg;
  logic [31:0] cycle_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retired_reg <= '0;
      cycle_reg   <= '0;
    end else begin
      if (retire) retired_reg <= retired_reg + 32'd1;
      if (busy)   cycle_reg   <= cycle_reg + 32'd1;
    end
  end

  assign retired_cnt = retired_reg;
  assign cycle_cnt   = cycle_reg;

endmodule

// File: rtl/arith_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback controller for the MIPS arithmetic datapath.
// Optional performance counters are enabled by defining ARITH_SEQ_PERF_EN.
module arith_sequencer
  import arith_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  input  logic        dec_except,
  input  logic        dec_writeenable,
  output logic        alu_latch,
  output logic        rf_wr_en,
  output logic [31:0] pc,
  output logic        busy,
  output logic        exc_valid,
  output logic [31:0] exc_pc,
  input  logic        exc_ack
`ifdef ARITH_SEQ_PERF_EN
  ,
  output logic [31:0] retired_cnt,
  output logic [31:0] cycle_cnt
`endif
);

  state_t      state_reg, state_next;
  logic [31:0] pc_reg;
  logic [31:0] instr_reg;
  logic [31:0] exc_pc_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:      if (run) state_next = ST_FETCH;
      ST_FETCH:     if (imem_ready) state_next = ST_DECODE;
      ST_DECODE:    state_next = dec_except ? ST_EXCEPT : ST_EXECUTE;
      ST_EXECUTE:   state_next = ST_WRITEBACK;
      ST_WRITEBACK: state_next = run ? ST_FETCH : ST_IDLE;
      ST_EXCEPT:    if (exc_ack) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // The PC also steps on exception acknowledge so the faulting word is skipped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      pc_reg     <= RESET_PC;
      instr_reg  <= '0;
      exc_pc_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_FETCH && imem_ready)
        instr_reg <= imem_data;
      if (state_reg == ST_DECODE && dec_except)
        exc_pc_reg <= pc_reg;
      if (state_reg == ST_WRITEBACK || (state_reg == ST_EXCEPT && exc_ack))
        pc_reg <= next_pc(pc_reg);
    end
  end

  assign imem_req  = (state_reg == ST_FETCH);
  assign imem_addr = pc_reg;
  assign instr     = instr_reg;
  assign alu_latch = (state_reg == ST_EXECUTE);
  assign rf_wr_en  = (state_reg == ST_WRITEBACK) && dec_writeenable;
  assign pc        = pc_reg;
  assign busy      = (state_reg != ST_IDLE) && (state_reg != ST_EXCEPT);
  assign exc_valid = (state_reg == ST_EXCEPT);
  assign exc_pc    = exc_pc_reg;

`ifdef ARITH_SEQ_PERF_EN
  arith_seq_perf u_perf (
    .clock       (clock),
    .reset       (reset),
    .retire      (state_reg == ST_WRITEBACK),
    .busy        (busy),
    .retired_cnt (retired_cnt),
    .cycle_cnt   (cycle_cnt)
  );
`endif

endmodule

// File: tb/tb_arith_sequencer.sv
// Self-checking bench for arith_sequencer: directed table, randomized instructions, reset corners.
module tb_arith_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_data = '0;
  logic        dec_except = 1'b0;
  logic        dec_writeenable = 1'b0;
  logic        exc_ack = 1'b0;

  logic        imem_req, alu_latch, rf_wr_en, busy, exc_valid;
  logic [31:0] imem_addr, instr, pc, exc_pc;

  logic        w_req, w_alu, w_wr, w_busy, w_exc;
  logic [31:0] w_addr, w_instr, w_pc, w_exc_pc;

`ifdef ARITH_SEQ_PERF_EN
  logic [31:0] retired_cnt, cycle_cnt, w_ret, w_cyc;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_pc;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  always #5 clock = ~clock;

  arith_sequencer dut (
    .clock(clock), .reset(reset), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_data(imem_data),
    .instr(instr), .dec_except(dec_except), .dec_writeenable(dec_writeenable),
    .alu_latch(alu_latch), .rf_wr_en(rf_wr_en), .pc(pc), .busy(busy),
    .exc_valid(exc_valid), .exc_pc(exc_pc), .exc_ack(exc_ack)
`ifdef ARITH_SEQ_PERF_EN
    , .retired_cnt(retired_cnt), .cycle_cnt(cycle_cnt)
`endif
  );

  // Same stimulus, reset PC at the top of the address space to exercise wrap.
  arith_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clock(clock), .reset(reset), .run(run),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ready(imem_ready), .imem_data(imem_data),
    .instr(w_instr), .dec_except(dec_except), .dec_writeenable(dec_writeenable),
    .alu_latch(w_alu), .rf_wr_en(w_wr), .pc(w_pc), .busy(w_busy),
    .exc_valid(w_exc), .exc_pc(w_exc_pc), .exc_ack(exc_ack)
`ifdef ARITH_SEQ_PERF_EN
    , .retired_cnt(w_ret), .cycle_cnt(w_cyc)
`endif
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic [31:0] data;
    int          waits;
    bit          exc;
    bit          we;
    bit          late_drop;
    int          exp_busy;
    logic [31:0] exp_pc;
  } vec_t;

  // One instruction from IDLE back to IDLE; checks are transaction-level counts.
  task automatic run_instr(input string tag, input logic [31:0] data, input int waits,
                           input bit exc, input bit we, input bit late_drop,
                           input int exp_busy, input logic [31:0] exp_pc);
    int req_cnt = 0, alu_cnt = 0, wr_cnt = 0, busy_cnt = 0, ovl = 0, addr_bad = 0;
    int hold = $urandom_range(0, 2);
    int guard = 0;
    bit done = 0, prev_alu = 0, exc_seen = 0;
    logic [31:0] start_pc = m_pc;
    dec_except = exc;
    dec_writeenable = we;
    imem_ready = 1'b0;
    run = 1'b1;
    while (!done && guard < 60) begin
      @(negedge clock);
      guard++;
      if (busy) busy_cnt++;
      if (alu_latch && rf_wr_en) ovl++;
      if (alu_latch) alu_cnt++;
      if (rf_wr_en) wr_cnt++;
      if (imem_req) begin
        req_cnt++;
        if (imem_addr != start_pc) addr_bad++;
        if (!late_drop) run = 1'b0;
      end
      if (alu_latch && late_drop) run = 1'b0;
      if (prev_alu) begin
        run = 1'b0;
        done = 1;
      end
      prev_alu = alu_latch;
      if (exc_valid) begin
        if (!exc_seen) begin
          chk({tag, " exc_pc"}, exc_pc, start_pc);
          chk({tag, " pc_in_exc"}, pc, start_pc);
        end
        exc_seen = 1;
        chk({tag, " busy_in_exc"}, {31'b0, busy}, 32'd0);
        if (hold > 0) begin
          run = 1'($urandom_range(0, 1));
          hold--;
        end else begin
          run = 1'b0;
          exc_ack = 1'b1;
          done = 1;
        end
      end
      if (imem_req) begin
        imem_ready = (req_cnt == waits + 1);
        imem_data  = imem_ready ? data : $urandom;
      end else begin
        imem_ready = 1'($urandom_range(0, 1));
        imem_data  = $urandom;
      end
    end
    chk({tag, " finished"}, {31'b0, done}, 32'd1);
    @(negedge clock);
    exc_ack = 1'b0;
    imem_ready = 1'b0;
    m_pc = start_pc + 32'd4;
    chk({tag, " req_cycles"}, req_cnt, waits + 1);
    chk({tag, " addr_stable"}, addr_bad, 0);
    chk({tag, " alu_pulses"}, alu_cnt, exc ? 0 : 1);
    chk({tag, " wr_pulses"}, wr_cnt, (!exc && we) ? 1 : 0);
    chk({tag, " overlap"}, ovl, 0);
    chk({tag, " busy_cycles"}, busy_cnt, exp_busy);
    chk({tag, " exc_seen"}, {31'b0, exc_seen}, {31'b0, exc});
    chk({tag, " instr"}, instr, data);
    chk({tag, " pc"}, pc, exp_pc);
    chk({tag, " model_pc"}, pc, m_pc);
    chk({tag, " idle"}, {30'b0, busy, exc_valid}, 32'd0);
    chk({tag, " wrap_pc"}, w_pc, m_pc - 32'h0040_0004);
    $display("txn %s data=%h waits=%0d exc=%0d we=%0d pc=%h", tag, data, waits, exc, we, pc);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " pc"}, pc, RST_PC);
    chk({tag, " addr"}, imem_addr, RST_PC);
    chk({tag, " instr"}, instr, 32'd0);
    chk({tag, " exc_pc"}, exc_pc, 32'd0);
    chk({tag, " bits"}, {27'b0, imem_req, alu_latch, rf_wr_en, busy, exc_valid}, 32'd0);
    chk({tag, " w_pc"}, w_pc, 32'hFFFF_FFFC);
  endtask

  task automatic release_reset();
    run = 1'b0;
    imem_ready = 1'b0;
    exc_ack = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    m_pc = RST_PC;
  endtask

  vec_t tbl[5];

  initial begin
    int guard;
    int wr_after;
    tbl[0] = '{32'h0109_5020, 0, 1'b0, 1'b1, 1'b0, 4, 32'h0040_0004};
    tbl[1] = '{32'h012A_5822, 3, 1'b0, 1'b1, 1'b0, 7, 32'h0040_0008};
    tbl[2] = '{32'hFC00_003F, 0, 1'b1, 1'b0, 1'b0, 2, 32'h0040_000C};
    tbl[3] = '{32'h014B_6024, 0, 1'b0, 1'b1, 1'b1, 4, 32'h0040_0010};
    tbl[4] = '{32'h0000_0000, 1, 1'b0, 1'b0, 1'b0, 5, 32'h0040_0014};

    repeat (2) @(negedge clock);
    check_reset_state("reset");
    release_reset();

    for (int i = 0; i < 5; i++)
      run_instr($sformatf("tbl%0d", i), tbl[i].data, tbl[i].waits, tbl[i].exc,
                tbl[i].we, tbl[i].late_drop, tbl[i].exp_busy, tbl[i].exp_pc);

    for (int i = 0; i < 30; i++) begin
      int  w = $urandom_range(0, 3);
      bit  e = ($urandom_range(0, 4) == 0);
      bit  we = 1'($urandom_range(0, 1));
      bit  ld = 1'($urandom_range(0, 1));
      run_instr($sformatf("rnd%0d", i), $urandom, w, e, we, ld, e ? w + 2 : w + 4, m_pc + 32'd4);
    end

    // Reset while a fetch is outstanding.
    run = 1'b1;
    imem_ready = 1'b0;
    guard = 0;
    do begin
      @(negedge clock);
      guard++;
    end while (!imem_req && guard < 10);
    chk("fetch_reached", {31'b0, imem_req}, 32'd1);
    @(negedge clock);
    #2 reset = 1'b1;
    #1 check_reset_state("rst_fetch");
    release_reset();

    // Reset during a writing WRITEBACK must kill the strobe at once.
    dec_except = 1'b0;
    dec_writeenable = 1'b1;
    imem_data = 32'h0109_5020;
    run = 1'b1;
    imem_ready = 1'b1;
    guard = 0;
    do begin
      @(negedge clock);
      guard++;
    end while (!rf_wr_en && guard < 10);
    chk("wb_reached", {31'b0, rf_wr_en}, 32'd1);
    #2 reset = 1'b1;
    #1 check_reset_state("rst_wb");
    release_reset();
    wr_after = 0;
    repeat (3) begin
      @(negedge clock);
      if (rf_wr_en || alu_latch) wr_after++;
    end
    chk("no_strobe_after_reset", wr_after, 0);
    chk("idle_after_reset", {31'b0, busy}, 32'd0);

`ifdef ARITH_SEQ_PERF_EN
    begin
      int alu_seen = 0;
      reset = 1'b1;
      #1 chk("perf_rst_ret", retired_cnt, 32'd0);
      chk("perf_rst_cyc", cycle_cnt, 32'd0);
      release_reset();
      dec_except = 1'b0;
      dec_writeenable = 1'b1;
      imem_ready = 1'b1;
      run = 1'b1;
      guard = 0;
      while (alu_seen < 3 && guard < 40) begin
        @(negedge clock);
        guard++;
        if (alu_latch) alu_seen++;
      end
      run = 1'b0;
      repeat (2) @(negedge clock);
      imem_ready = 1'b0;
      chk("perf_retired", retired_cnt, 32'd3);
      chk("perf_cycles", cycle_cnt, 32'd12);
      $display("txn perf retired=%0d cycles=%0d", retired_cnt, cycle_cnt);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
